// File: rtl/ex_operand_stage_pkg.sv
// Shared ALU operation codes and register-file conventions for the EX operand stage.
// ALU_ADD doubles as the control value parked in bubble slots.
package ex_operand_stage_pkg;

    localparam int ALU_CTRL_W = 5;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9
    } alu_op_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/ex_fwd_mux.sv
// Operand forwarding mux, present only when RISCX_FWD_EN is defined: x0 reads zero, EX/MEM beats MEM/WB beats regfile.
// Purely combinational (0 cycles); no flow control of its own.
`ifdef RISCX_FWD_EN
module ex_fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [REG_AW-1:0] fwd1_rd,
    input  logic              fwd1_we,
    input  logic [DATA_W-1:0] fwd1_data,
    input  logic [REG_AW-1:0] fwd2_rd,
    input  logic              fwd2_we,
    input  logic [DATA_W-1:0] fwd2_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = rs_data;
        if (rs == REG_AW'(REG_ZERO))
            data = '0;
        else if (fwd1_we && (fwd1_rd == rs))
            data = fwd1_data;
        else if (fwd2_we && (fwd2_rd == rs))
            data = fwd2_data;
    end

endmodule
`endif

// File: rtl/ex_operand_stage.sv
// ID/EX register feeding the ALU: forwarding (RISCX_FWD_EN) or interlock, A/B source select, 1-cycle latency.
// Holds on iReady=0 while valid; load-use / RAW hazards drop oReady and insert a bubble; iFlush kills even when stalled.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5,
    parameter int REG_AW = 5
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iValid,
    output logic              oReady,
    input  logic [REG_AW-1:0] iRs1,
    input  logic [REG_AW-1:0] iRs2,
    input  logic [DATA_W-1:0] iRs1Data,
    input  logic [DATA_W-1:0] iRs2Data,
    input  logic [DATA_W-1:0] iImm,
    input  logic [DATA_W-1:0] iPC,
    input  logic              iUsePC,
    input  logic              iUseImm,
    input  logic [CTRL_W-1:0] iAluCtrl,
    input  logic [REG_AW-1:0] iRd,
    input  logic              iRegWrite,
    input  logic              iMemRead,
    input  logic [REG_AW-1:0] iFwd1Rd,
    input  logic              iFwd1We,
    input  logic [DATA_W-1:0] iFwd1Data,
    input  logic [REG_AW-1:0] iFwd2Rd,
    input  logic              iFwd2We,
    input  logic [DATA_W-1:0] iFwd2Data,
    input  logic              iFlush,
    input  logic              iReady,
    output logic              oValid,
    output logic [DATA_W-1:0] oA,
    output logic [DATA_W-1:0] oB,
    output logic [DATA_W-1:0] oStoreData,
    output logic [CTRL_W-1:0] oAluCtrl,
    output logic [REG_AW-1:0] oRd,
    output logic              oRegWrite,
    output logic              oMemRead
);

    localparam logic [REG_AW-1:0] X0          = REG_AW'(REG_ZERO);
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(ALU_ADD);

    logic              advance;
    logic              load_use;
    logic              hazard;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;

    assign advance  = iReady | ~oValid;
    // rs2 counts as a source even with iUseImm: stores still need it as data.
    assign load_use = oValid & oMemRead & (oRd != X0) &
                      (((oRd == iRs1) & ~iUsePC) | (oRd == iRs2));

`ifdef RISCX_FWD_EN
    ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs        (iRs1),
        .rs_data   (iRs1Data),
        .fwd1_rd   (iFwd1Rd),
        .fwd1_we   (iFwd1We),
        .fwd1_data (iFwd1Data),
        .fwd2_rd   (iFwd2Rd),
        .fwd2_we   (iFwd2We),
        .fwd2_data (iFwd2Data),
        .data      (rs1_val)
    );

    ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs        (iRs2),
        .rs_data   (iRs2Data),
        .fwd1_rd   (iFwd1Rd),
        .fwd1_we   (iFwd1We),
        .fwd1_data (iFwd1Data),
        .fwd2_rd   (iFwd2Rd),
        .fwd2_we   (iFwd2We),
        .fwd2_data (iFwd2Data),
        .data      (rs2_val)
    );

    assign hazard = load_use;
`else
    logic rs1_busy;
    logic rs2_busy;
    logic unused_fwd_data;

    // Without bypass paths any in-flight writer of a used source must drain first.
    assign rs1_busy = (oValid & oRegWrite & (oRd == iRs1)) |
                      (iFwd1We & (iFwd1Rd == iRs1)) |
                      (iFwd2We & (iFwd2Rd == iRs1));
    assign rs2_busy = (oValid & oRegWrite & (oRd == iRs2)) |
                      (iFwd1We & (iFwd1Rd == iRs2)) |
                      (iFwd2We & (iFwd2Rd == iRs2));

    assign hazard = load_use |
                    ((iRs1 != X0) & ~iUsePC & rs1_busy) |
                    ((iRs2 != X0) & rs2_busy);

    assign rs1_val         = iRs1Data;
    assign rs2_val         = iRs2Data;
    assign unused_fwd_data = ^{iFwd1Data, iFwd2Data};
`endif

    assign oReady = advance & ~hazard & ~iFlush;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oValid     <= 1'b0;
            oA         <= '0;
            oB         <= '0;
            oStoreData <= '0;
            oAluCtrl   <= '0;
            oRd        <= '0;
            oRegWrite  <= 1'b0;
            oMemRead   <= 1'b0;
        end else if (iFlush || (advance && hazard)) begin
            // Killed slots must not look like writers to later forwarding logic.
            oValid    <= 1'b0;
            oRegWrite <= 1'b0;
            oMemRead  <= 1'b0;
            oAluCtrl  <= BUBBLE_CTRL;
        end else if (advance) begin
            oValid     <= iValid;
            oA         <= iUsePC  ? iPC  : rs1_val;
            oB         <= iUseImm ? iImm : rs2_val;
            oStoreData <= rs2_val;
            oAluCtrl   <= iAluCtrl;
            oRd        <= iRd;
            oRegWrite  <= iValid & iRegWrite;
            oMemRead   <= iValid & iMemRead;
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: reset, operand table, hand-written hazard/stall/flush/reset sequences, random vs model.
module tb_ex_operand_stage;

`ifdef RISCX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2;
        logic [31:0] d1, d2, imm, pc;
        logic        usepc, useimm;
        logic [4:0]  ctrl, rd;
        logic        rw, mr;
        logic [4:0]  f1rd;
        logic        f1we;
        logic [31:0] f1d;
        logic [4:0]  f2rd;
        logic        f2we;
        logic [31:0] f2d;
        logic        flush, ready;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] ea, eb, esd;   // operands when bypassing is built in
        logic        hz_nf;         // interlock expected when bypassing is absent
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] a, b, sd;
        logic [4:0]  ctrl, rd;
        logic        rw, mr, ctl_known;
    } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iValid, iUsePC, iUseImm, iRegWrite, iMemRead, iFwd1We, iFwd2We, iFlush, iReady;
    logic [4:0]  iRs1, iRs2, iAluCtrl, iRd, iFwd1Rd, iFwd2Rd;
    logic [31:0] iRs1Data, iRs2Data, iImm, iPC, iFwd1Data, iFwd2Data;
    logic        oReady, oValid, oRegWrite, oMemRead;
    logic [31:0] oA, oB, oStoreData;
    logic [4:0]  oAluCtrl, oRd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.DATA_W(32), .CTRL_W(5), .REG_AW(5)) dut (
        .iCLK(clk), .iRST(rst), .iValid(iValid), .oReady(oReady),
        .iRs1(iRs1), .iRs2(iRs2), .iRs1Data(iRs1Data), .iRs2Data(iRs2Data),
        .iImm(iImm), .iPC(iPC), .iUsePC(iUsePC), .iUseImm(iUseImm), .iAluCtrl(iAluCtrl),
        .iRd(iRd), .iRegWrite(iRegWrite), .iMemRead(iMemRead),
        .iFwd1Rd(iFwd1Rd), .iFwd1We(iFwd1We), .iFwd1Data(iFwd1Data),
        .iFwd2Rd(iFwd2Rd), .iFwd2We(iFwd2We), .iFwd2Data(iFwd2Data),
        .iFlush(iFlush), .iReady(iReady), .oValid(oValid), .oA(oA), .oB(oB),
        .oStoreData(oStoreData), .oAluCtrl(oAluCtrl), .oRd(oRd),
        .oRegWrite(oRegWrite), .oMemRead(oMemRead)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        iValid = s.valid;  iRs1 = s.rs1;  iRs2 = s.rs2;  iRs1Data = s.d1;  iRs2Data = s.d2;
        iImm = s.imm;  iPC = s.pc;  iUsePC = s.usepc;  iUseImm = s.useimm;  iAluCtrl = s.ctrl;
        iRd = s.rd;  iRegWrite = s.rw;  iMemRead = s.mr;
        iFwd1Rd = s.f1rd;  iFwd1We = s.f1we;  iFwd1Data = s.f1d;
        iFwd2Rd = s.f2rd;  iFwd2We = s.f2we;  iFwd2Data = s.f2d;
        iFlush = s.flush;  iReady = s.ready;
    endtask

    function automatic stim_t op(input logic [4:0] rs1, input logic [31:0] d1,
                                 input logic [4:0] rs2, input logic [31:0] d2);
        stim_t s;
        s = '{valid: 1'b1, rs1: rs1, rs2: rs2, d1: d1, d2: d2, imm: 32'h0, pc: 32'h0,
              usepc: 1'b0, useimm: 1'b0, ctrl: 5'd0, rd: 5'd0, rw: 1'b0, mr: 1'b0,
              f1rd: 5'd0, f1we: 1'b0, f1d: 32'h0, f2rd: 5'd0, f2we: 1'b0, f2d: 32'h0,
              flush: 1'b0, ready: 1'b1};
        return s;
    endfunction

    // Value the ALU should see for a source register, by the bypass priority rules.
    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf, input stim_t s);
        if (!FWD) return rf;
        if (rs == 5'd0) return 32'h0;
        if (s.f1we && s.f1rd == rs) return s.f1d;
        if (s.f2we && s.f2rd == rs) return s.f2d;
        return rf;
    endfunction

    // True when the incoming instruction must wait: a used, non-zero source is still being produced.
    function automatic logic must_wait(input st_t m, input stim_t s);
        logic [4:0] srcs[$];
        logic [4:0] writers[$];
        if (!s.usepc) srcs.push_back(s.rs1);
        srcs.push_back(s.rs2);
        if (!FWD) begin
            if (m.valid && m.rw) writers.push_back(m.rd);
            if (s.f1we) writers.push_back(s.f1rd);
            if (s.f2we) writers.push_back(s.f2rd);
        end
        foreach (srcs[i]) begin
            if (srcs[i] == 5'd0) continue;
            if (m.valid && m.mr && m.rd == srcs[i]) return 1'b1;
            foreach (writers[j]) if (writers[j] == srcs[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic st_t step(input st_t m, input stim_t s, input logic hz);
        st_t  n;
        logic adv;
        n   = m;
        adv = s.ready || !m.valid;
        if (s.flush || (adv && hz)) begin
            n.valid = 1'b0;  n.rw = 1'b0;  n.mr = 1'b0;  n.ctl_known = 1'b1;
        end else if (adv) begin
            n.valid = s.valid;
            n.a     = s.usepc  ? s.pc  : operand(s.rs1, s.d1, s);
            n.b     = s.useimm ? s.imm : operand(s.rs2, s.d2, s);
            n.sd    = operand(s.rs2, s.d2, s);
            n.ctrl  = s.ctrl;  n.rd = s.rd;  n.rw = s.rw;  n.mr = s.mr;
            n.ctl_known = s.valid;
        end
        return n;
    endfunction

    task automatic compare_state(input string tag, input st_t m);
        check({tag, " oValid"}, {31'h0, oValid}, {31'h0, m.valid});
        if (m.valid) begin
            check({tag, " oA"}, oA, m.a);
            check({tag, " oB"}, oB, m.b);
            check({tag, " oStoreData"}, oStoreData, m.sd);
            check({tag, " oAluCtrl"}, {27'h0, oAluCtrl}, {27'h0, m.ctrl});
            check({tag, " oRd"}, {27'h0, oRd}, {27'h0, m.rd});
        end
        if (m.ctl_known) begin
            check({tag, " oRegWrite"}, {31'h0, oRegWrite}, {31'h0, m.rw});
            check({tag, " oMemRead"}, {31'h0, oMemRead}, {31'h0, m.mr});
        end
    endtask

    initial begin
        vec_t  vec[7];
        stim_t s;
        st_t   m;
        logic  hz, exp_rdy;
        logic [31:0] ea, eb, esd;

        drive(op(5'd0, 32'h0, 5'd0, 32'h0));
        iValid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset oValid", {31'h0, oValid}, 32'h0);
        check("reset oA", oA, 32'h0);
        check("reset oB", oB, 32'h0);
        check("reset oStoreData", oStoreData, 32'h0);
        check("reset oAluCtrl", {27'h0, oAluCtrl}, 32'h0);
        check("reset oRd", {27'h0, oRd}, 32'h0);
        check("reset oRegWrite", {31'h0, oRegWrite}, 32'h0);
        check("reset oMemRead", {31'h0, oMemRead}, 32'h0);
        rst = 1'b0;

        // Operand table: every vector starts from a stage holding nothing that writes a register.
        vec[0].s = op(5'd1, 32'h11, 5'd2, 32'h22);
        vec[0].ea = 32'h11;  vec[0].eb = 32'h22;  vec[0].esd = 32'h22;  vec[0].hz_nf = 1'b0;
        vec[1].s = op(5'd3, 32'h33, 5'd3, 32'h33);
        vec[1].s.f1rd = 5'd3;  vec[1].s.f1we = 1'b1;  vec[1].s.f1d = 32'd7;
        vec[1].ea = 32'd7;  vec[1].eb = 32'd7;  vec[1].esd = 32'd7;  vec[1].hz_nf = 1'b1;
        vec[2].s = op(5'd5, 32'h55, 5'd2, 32'h22);
        vec[2].s.f1rd = 5'd5;  vec[2].s.f1we = 1'b1;  vec[2].s.f1d = 32'd11;
        vec[2].s.f2rd = 5'd5;  vec[2].s.f2we = 1'b1;  vec[2].s.f2d = 32'd22;
        vec[2].ea = 32'd11;  vec[2].eb = 32'h22;  vec[2].esd = 32'h22;  vec[2].hz_nf = 1'b1;
        vec[3].s = op(5'd1, 32'h11, 5'd6, 32'h60);
        vec[3].s.f2rd = 5'd6;  vec[3].s.f2we = 1'b1;  vec[3].s.f2d = 32'h66;
        vec[3].ea = 32'h11;  vec[3].eb = 32'h66;  vec[3].esd = 32'h66;  vec[3].hz_nf = 1'b1;
        vec[4].s = op(5'd0, 32'h5, 5'd0, 32'h9);
        vec[4].s.f1rd = 5'd0;  vec[4].s.f1we = 1'b1;  vec[4].s.f1d = 32'hAA;
        vec[4].ea = 32'h0;  vec[4].eb = 32'h0;  vec[4].esd = 32'h0;  vec[4].hz_nf = 1'b0;
        vec[5].s = op(5'd4, 32'h44, 5'd7, 32'h27);
        vec[5].s.usepc = 1'b1;  vec[5].s.pc = 32'h100;  vec[5].s.useimm = 1'b1;  vec[5].s.imm = 32'hFFFF_FFFC;
        vec[5].s.f1rd = 5'd4;  vec[5].s.f1we = 1'b1;  vec[5].s.f1d = 32'hBAD;
        vec[5].s.f2rd = 5'd7;  vec[5].s.f2we = 1'b0;  vec[5].s.f2d = 32'hBAD2;
        vec[5].ea = 32'h100;  vec[5].eb = 32'hFFFF_FFFC;  vec[5].esd = 32'h27;  vec[5].hz_nf = 1'b0;
        vec[6].s = op(5'd3, 32'h1234, 5'd2, 32'h22);
        vec[6].s.f1rd = 5'd3;  vec[6].s.f1we = 1'b0;  vec[6].s.f1d = 32'hDEAD;
        vec[6].ea = 32'h1234;  vec[6].eb = 32'h22;  vec[6].esd = 32'h22;  vec[6].hz_nf = 1'b0;

        foreach (vec[i]) begin
            s       = vec[i].s;
            exp_rdy = FWD ? 1'b1 : !vec[i].hz_nf;
            ea      = FWD ? vec[i].ea  : (s.usepc  ? s.pc  : s.d1);
            eb      = FWD ? vec[i].eb  : (s.useimm ? s.imm : s.d2);
            esd     = FWD ? vec[i].esd : s.d2;
            drive(s);
            #1;
            check($sformatf("vec%0d oReady", i), {31'h0, oReady}, {31'h0, exp_rdy});
            @(negedge clk);
            check($sformatf("vec%0d oValid", i), {31'h0, oValid}, {31'h0, exp_rdy});
            if (exp_rdy) begin
                check($sformatf("vec%0d oA", i), oA, ea);
                check($sformatf("vec%0d oB", i), oB, eb);
                check($sformatf("vec%0d oStoreData", i), oStoreData, esd);
            end
        end

        // Load-use: LW x6 enters, dependent ADD waits one cycle behind a bubble.
        s = op(5'd1, 32'h1, 5'd0, 32'h0);
        s.rd = 5'd6;  s.rw = 1'b1;  s.mr = 1'b1;
        drive(s);
        @(negedge clk);
        s = op(5'd6, 32'h600, 5'd2, 32'h22);
        s.rd = 5'd7;  s.rw = 1'b1;
        drive(s);
        #1;
        check("loaduse oReady stalled", {31'h0, oReady}, 32'h0);
        @(negedge clk);
        check("loaduse bubble oValid", {31'h0, oValid}, 32'h0);
        check("loaduse bubble oRegWrite", {31'h0, oRegWrite}, 32'h0);
        check("loaduse oReady released", {31'h0, oReady}, 32'h1);
        @(negedge clk);
        check("loaduse issue oValid", {31'h0, oValid}, 32'h1);
        check("loaduse issue oA", oA, 32'h600);

        // Downstream stall holds the instruction; flush kills it despite the stall.
        s = op(5'd1, 32'h1234, 5'd2, 32'h22);
        drive(s);
        @(negedge clk);
        s.d1 = 32'h9999;  s.ready = 1'b0;
        drive(s);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d oReady", k), {31'h0, oReady}, 32'h0);
            @(negedge clk);
            check($sformatf("stall%0d oValid", k), {31'h0, oValid}, 32'h1);
            check($sformatf("stall%0d oA", k), oA, 32'h1234);
        end
        s.flush = 1'b1;
        drive(s);
        @(negedge clk);
        check("flush-in-stall oValid", {31'h0, oValid}, 32'h0);

        // Reset mid-run clears outputs without waiting for a clock edge.
        s = op(5'd1, 32'hABCD, 5'd2, 32'h22);
        drive(s);
        @(negedge clk);
        check("pre-reset oValid", {31'h0, oValid}, 32'h1);
        rst = 1'b1;
        #1;
        check("async reset oValid", {31'h0, oValid}, 32'h0);
        check("async reset oA", oA, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        s.valid = 1'b0;
        drive(s);
        #1;
        check("post-reset oValid", {31'h0, oValid}, 32'h0);

        // Random traffic against the reference model.
        m = '{valid: 1'b0, a: 32'h0, b: 32'h0, sd: 32'h0, ctrl: 5'd0, rd: 5'd0,
              rw: 1'b0, mr: 1'b0, ctl_known: 1'b1};
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            compare_state($sformatf("rand%0d", c), m);
            s = op(5'($urandom_range(7)), $urandom, 5'($urandom_range(7)), $urandom);
            s.valid  = ($urandom_range(3) != 0);
            s.usepc  = ($urandom_range(3) == 0);
            s.useimm = ($urandom_range(1) == 0);
            s.pc     = $urandom;  s.imm = $urandom;  s.ctrl = 5'($urandom_range(9));
            s.rd     = 5'($urandom_range(7));
            s.rw     = $urandom_range(1) == 1;
            s.mr     = ($urandom_range(3) == 0);
            s.f1rd   = 5'($urandom_range(7));  s.f1we = ($urandom_range(2) == 0);  s.f1d = $urandom;
            s.f2rd   = 5'($urandom_range(7));  s.f2we = ($urandom_range(2) == 0);  s.f2d = $urandom;
            s.flush  = ($urandom_range(15) == 0);
            s.ready  = ($urandom_range(3) != 0);
            drive(s);
            #1;
            hz = must_wait(m, s);
            exp_rdy = (s.ready || !m.valid) && !hz && !s.flush;
            check($sformatf("rand%0d oReady", c), {31'h0, oReady}, {31'h0, exp_rdy});
            m = step(m, s, hz);
        end
        @(negedge clk);
        compare_state("rand-final", m);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
